// File: rtl/psg_seq_pkg.sv
// rtl/psg_seq_pkg.sv - shared state and bus-mode definitions for the ym2149 PSG bus sequencer
package psg_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        GAP  = 2'd3
    } psg_seq_state_t;

    // {BDIR, BC} encodings driven onto the PSG
    localparam logic [1:0] PSG_BUS_IDLE  = 2'b00;
    localparam logic [1:0] PSG_BUS_READ  = 2'b01;
    localparam logic [1:0] PSG_BUS_WRITE = 2'b10;
    localparam logic [1:0] PSG_BUS_ADDR  = 2'b11;

endpackage

// File: rtl/psg_seq_arbiter.sv
// rtl/psg_seq_arbiter.sv - two-port fixed-priority arbiter with port-1 starvation guard
module psg_seq_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_arb_en,
    input  logic i_req0,
    input  logic i_req1,
    output logic o_grant_idx,
    output logic o_grant_valid
);
    import psg_seq_pkg::*;

    localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    logic [SW-1:0] r_starve_cnt;
    logic          w_force1;

    assign w_force1      = i_req1 && (r_starve_cnt == LIMIT);
    assign o_grant_valid = i_req0 | i_req1;
    assign o_grant_idx   = !i_req0 || w_force1;

    // Counter only moves on arbitration cycles; it counts port-0 wins that made port 1 wait
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_starve_cnt <= '0;
        end else if (i_arb_en) begin
            if (!i_req1 || o_grant_idx) begin
                r_starve_cnt <= '0;
            end else if (r_starve_cnt != LIMIT) begin
                r_starve_cnt <= r_starve_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/psg_bus_sequencer.sv
// rtl/psg_bus_sequencer.sv - ym2149 bus master: arbitrates two requesters and runs ADDR/DATA/GAP cycles
// Optional latched-address cache enabled by defining PSG_ADDR_CACHE_EN.
module psg_bus_sequencer #(
    parameter int PHASE_CYCLES = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_req0,
    input  logic       i_req1,
    input  logic       i_we0,
    input  logic       i_we1,
    input  logic [3:0] i_addr0,
    input  logic [3:0] i_addr1,
    input  logic [7:0] i_wdata0,
    input  logic [7:0] i_wdata1,
    output logic       o_ack0,
    output logic       o_ack1,
    output logic [7:0] o_rdata0,
    output logic [7:0] o_rdata1,
    input  logic       i_cache_inv,
    output logic       o_psg_bdir,
    output logic       o_psg_bc,
    output logic [7:0] o_psg_di,
    input  logic [7:0] i_psg_do,
    output logic       o_busy
);
    import psg_seq_pkg::*;

    localparam logic [3:0] PHASE_RELOAD = 4'(PHASE_CYCLES - 1);

    psg_seq_state_t r_state;
    psg_seq_state_t w_state_nxt;
    logic [3:0]     r_phase_cnt;
    logic           r_grant;
    logic           r_we;
    logic [3:0]     r_addr;
    logic [7:0]     r_wdata;
    logic [7:0]     r_rdata0;
    logic [7:0]     r_rdata1;

    logic           w_arb_en;
    logic           w_grant_idx;
    logic           w_grant_valid;
    logic           w_phase_done;
    logic           w_first_gap;
    logic           w_hit;
    logic [3:0]     w_sel_addr;
    logic [1:0]     w_bus;

    assign w_arb_en     = (r_state == IDLE);
    assign w_phase_done = (r_phase_cnt == 4'd0);
    assign w_sel_addr   = w_grant_idx ? i_addr1 : i_addr0;

    psg_seq_arbiter #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_arbiter (
        .i_clk         (i_clk),
        .i_reset_n     (i_reset_n),
        .i_arb_en      (w_arb_en),
        .i_req0        (i_req0),
        .i_req1        (i_req1),
        .o_grant_idx   (w_grant_idx),
        .o_grant_valid (w_grant_valid)
    );

`ifdef PSG_ADDR_CACHE_EN
    logic       r_cache_valid;
    logic [3:0] r_cache_addr;

    // An invalidate in the same cycle as the ADDR exit leaves the cache invalid
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_cache_valid <= 1'b0;
            r_cache_addr  <= 4'h0;
        end else if (i_cache_inv) begin
            r_cache_valid <= 1'b0;
        end else if (r_state == ADDR && w_phase_done) begin
            r_cache_valid <= 1'b1;
            r_cache_addr  <= r_addr;
        end
    end

    assign w_hit = r_cache_valid && !i_cache_inv && (r_cache_addr == w_sel_addr);
`else
    logic w_unused_cache_inv;
    assign w_unused_cache_inv = i_cache_inv;
    assign w_hit              = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (w_grant_valid) w_state_nxt = w_hit ? DATA : ADDR;
            ADDR: if (w_phase_done)  w_state_nxt = DATA;
            DATA: if (w_phase_done)  w_state_nxt = GAP;
            GAP:  if (w_phase_done)  w_state_nxt = IDLE;
            default:                 w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state     <= IDLE;
            r_phase_cnt <= PHASE_RELOAD;
        end else begin
            r_state <= w_state_nxt;
            if (w_state_nxt != r_state) begin
                r_phase_cnt <= PHASE_RELOAD;
            end else if (r_state != IDLE && !w_phase_done) begin
                r_phase_cnt <= r_phase_cnt - 4'd1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_grant  <= 1'b0;
            r_we     <= 1'b0;
            r_addr   <= 4'h0;
            r_wdata  <= 8'h00;
            r_rdata0 <= 8'h00;
            r_rdata1 <= 8'h00;
        end else begin
            if (r_state == IDLE && w_grant_valid) begin
                r_grant <= w_grant_idx;
                r_we    <= w_grant_idx ? i_we1    : i_we0;
                r_addr  <= w_sel_addr;
                r_wdata <= w_grant_idx ? i_wdata1 : i_wdata0;
            end
            // DO is sampled on the last DATA clock so RDATA is valid alongside ACK
            if (r_state == DATA && w_phase_done && !r_we) begin
                if (r_grant) r_rdata1 <= i_psg_do;
                else         r_rdata0 <= i_psg_do;
            end
        end
    end

    always_comb begin
        w_bus    = PSG_BUS_IDLE;
        o_psg_di = 8'h00;
        case (r_state)
            ADDR: begin
                w_bus    = PSG_BUS_ADDR;
                o_psg_di = {4'h0, r_addr};
            end
            DATA: begin
                w_bus    = r_we ? PSG_BUS_WRITE : PSG_BUS_READ;
                o_psg_di = r_we ? r_wdata : 8'h00;
            end
            default: begin
                w_bus    = PSG_BUS_IDLE;
                o_psg_di = 8'h00;
            end
        endcase
    end

    assign w_first_gap = (r_state == GAP) && (r_phase_cnt == PHASE_RELOAD);
    assign o_psg_bdir  = w_bus[1];
    assign o_psg_bc    = w_bus[0];
    assign o_ack0      = w_first_gap && !r_grant;
    assign o_ack1      = w_first_gap && r_grant;
    assign o_rdata0    = r_rdata0;
    assign o_rdata1    = r_rdata1;
    assign o_busy      = (r_state != IDLE);

endmodule

// File: tb/tb_psg_bus_sequencer.sv
// tb/tb_psg_bus_sequencer.sv - scoreboard bench for psg_bus_sequencer (PHASE_CYCLES 1 and 3 instances)
module tb_psg_bus_sequencer;
    import psg_seq_pkg::*;

`ifdef PSG_ADDR_CACHE_EN
    localparam bit CACHE_ON = 1'b1;
`else
    localparam bit CACHE_ON = 1'b0;
`endif

    typedef struct {
        int         dut;
        bit         port;
        bit         chk_rd;
        logic [7:0] rd;
        int         cyc;
        string      nm;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0_a, req1_a, req0_b, req1_b;
    logic       we0, we1, cache_inv;
    logic [3:0] addr0, addr1;
    logic [7:0] wdata0, wdata1, psg_do;

    logic       ack0_a, ack1_a, bdir_a, bc_a, busy_a;
    logic [7:0] rdata0_a, rdata1_a, di_a;
    logic       ack0_b, ack1_b, bdir_b, bc_b, busy_b;
    logic [7:0] rdata0_b, rdata1_b, di_b;

    exp_t q[$];
    int   cyc = 0;
    int   n_total = 0;
    int   n_pass = 0;
    int   n_acks = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    psg_bus_sequencer #(.PHASE_CYCLES(1), .STARVE_LIMIT(4)) u_dut (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_req0(req0_a), .i_req1(req1_a), .i_we0(we0), .i_we1(we1),
        .i_addr0(addr0), .i_addr1(addr1), .i_wdata0(wdata0), .i_wdata1(wdata1),
        .o_ack0(ack0_a), .o_ack1(ack1_a), .o_rdata0(rdata0_a), .o_rdata1(rdata1_a),
        .i_cache_inv(cache_inv), .o_psg_bdir(bdir_a), .o_psg_bc(bc_a), .o_psg_di(di_a),
        .i_psg_do(psg_do), .o_busy(busy_a)
    );

    psg_bus_sequencer #(.PHASE_CYCLES(3), .STARVE_LIMIT(4)) u_dut3 (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_req0(req0_b), .i_req1(req1_b), .i_we0(we0), .i_we1(we1),
        .i_addr0(addr0), .i_addr1(addr1), .i_wdata0(wdata0), .i_wdata1(wdata1),
        .o_ack0(ack0_b), .o_ack1(ack1_b), .o_rdata0(rdata0_b), .o_rdata1(rdata1_b),
        .i_cache_inv(cache_inv), .o_psg_bdir(bdir_b), .o_psg_bc(bc_b), .o_psg_di(di_b),
        .i_psg_do(psg_do), .o_busy(busy_b)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    task automatic mon(input int dut, input logic a0, input logic a1,
                       input logic [7:0] r0, input logic [7:0] r1);
        exp_t e;
        n_acks++;
        if (a0 && a1) begin
            chk("dual_ack", 32'(a0 & a1), 32'd0);
            return;
        end
        if (q.size() == 0) begin
            chk("unexpected_ack_queue_size", 32'(q.size()), 32'd1);
            return;
        end
        e = q.pop_front();
        chk({e.nm, "_dut"},   32'(dut), 32'(e.dut));
        chk({e.nm, "_port"},  32'(a1),  32'(e.port));
        chk({e.nm, "_cycle"}, 32'(cyc), 32'(e.cyc));
        if (e.chk_rd) chk({e.nm, "_rdata"}, 32'(a1 ? r1 : r0), 32'(e.rd));
    endtask

    always @(negedge clk) begin
        if (ack0_a || ack1_a) mon(0, ack0_a, ack1_a, rdata0_a, rdata1_a);
        if (ack0_b || ack1_b) mon(1, ack0_b, ack1_b, rdata0_b, rdata1_b);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int dut, input bit port, input bit we, input logic [3:0] a,
                         input logic [7:0] wd, input bit push, input bit chk_rd,
                         input logic [7:0] rd, input int lat, input string nm);
        if (port) begin we1 = we; addr1 = a; wdata1 = wd; end
        else      begin we0 = we; addr0 = a; wdata0 = wd; end
        if (push) q.push_back('{dut, port, chk_rd, rd, cyc + lat, nm});
        if (dut == 1)  req0_b = 1'b1;
        else if (port) req1_a = 1'b1;
        else           req0_a = 1'b1;
    endtask

    task automatic chk_bus_a(input string nm, input logic [1:0] bus, input logic [7:0] di);
        chk(nm, {22'h0, bdir_a, bc_a, di_a}, {22'h0, bus, di});
    endtask

    task automatic run_write0(input logic [3:0] a, input logic [7:0] wd, input bit hit,
                              input string nm);
        issue(0, 1'b0, 1'b1, a, wd, 1'b1, 1'b0, 8'h00, hit ? 2 : 3, nm);
        if (!hit) begin
            tick();
            chk_bus_a({nm, "_addr_phase"}, PSG_BUS_ADDR, {4'h0, a});
        end
        tick();
        chk_bus_a({nm, "_data_phase"}, PSG_BUS_WRITE, wd);
        tick();
        chk_bus_a({nm, "_gap_phase"}, PSG_BUS_IDLE, 8'h00);
        tick();
        chk({nm, "_busy_after"}, 32'(busy_a), 32'd0);
        req0_a = 1'b0;
        tick();
    endtask

    initial begin
        int base;
        bit done;
        rst_n = 1'b0;
        req0_a = 0; req1_a = 0; req0_b = 0; req1_b = 0;
        we0 = 0; we1 = 0; addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
        psg_do = 8'h00; cache_inv = 0;
        tick(); tick();
        chk("reset_bus", {22'h0, bdir_a, bc_a, di_a}, 32'h0);
        chk("reset_busy_ack", {29'h0, busy_a, ack0_a, ack1_a}, 32'h0);
        chk("reset_rdata", {16'h0, rdata0_a, rdata1_a}, 32'h0);
        rst_n = 1'b1;
        tick();

        // 1: port-0 write, reg 7
        run_write0(4'd7, 8'h38, 1'b0, "wr0_r7");

        // 2: port-1 read, reg 14
        psg_do = 8'hA5;
        issue(0, 1'b1, 1'b0, 4'd14, 8'h00, 1'b1, 1'b1, 8'hA5, 3, "rd1_r14");
        tick(); chk_bus_a("rd1_addr_phase", PSG_BUS_ADDR, 8'h0E);
        tick(); chk_bus_a("rd1_data_phase", PSG_BUS_READ, 8'h00);
        tick();
        chk("rd1_rdata1", 32'(rdata1_a), 32'hA5);
        chk("rd1_rdata0_unchanged", 32'(rdata0_a), 32'h00);
        tick(); chk("rd1_busy_after", 32'(busy_a), 32'd0);
        req1_a = 1'b0;
        psg_do = 8'h00;
        tick();

        // 4: address cache behaviour on reg 8
        run_write0(4'd8, 8'h11, 1'b0, "c_first");
        run_write0(4'd8, 8'h22, CACHE_ON, "c_second");
        cache_inv = 1'b1;
        tick();
        cache_inv = 1'b0;
        run_write0(4'd8, 8'h33, 1'b0, "c_after_inv");

        // 3: both ports held continuously, grant order 0,0,0,0,1 repeating
        base = cyc;
        for (int k = 0; k < 10; k++)
            q.push_back('{0, (k % 5) == 4, 1'b0, 8'h00, base + 3 + 4 * k, $sformatf("starve%0d", k)});
        we0 = 1; addr0 = 4'd1; wdata0 = 8'h11;
        we1 = 1; addr1 = 4'd2; wdata1 = 8'h22;
        req0_a = 1'b1; req1_a = 1'b1;
        n_acks = 0;
        done = 0;
        for (int i = 0; i < 80 && !done; i++) begin
            tick();
            if (n_acks >= 10) done = 1;
        end
        req0_a = 1'b0; req1_a = 1'b0;
        chk("starve_ack_count", 32'(n_acks), 32'd10);
        tick(); tick();

        // 5: PHASE_CYCLES=3 write on the second instance
        issue(1, 1'b0, 1'b1, 4'd3, 8'h5A, 1'b1, 1'b0, 8'h00, 7, "pc3_wr");
        for (int k = 1; k <= 9; k++) begin
            logic [1:0] eb;
            logic [7:0] ed;
            tick();
            eb = (k <= 3) ? PSG_BUS_ADDR : (k <= 6) ? PSG_BUS_WRITE : PSG_BUS_IDLE;
            ed = (k <= 3) ? 8'h03 : (k <= 6) ? 8'h5A : 8'h00;
            chk($sformatf("pc3_bus_c%0d", k), {22'h0, bdir_b, bc_b, di_b}, {22'h0, eb, ed});
            if (k >= 7) chk($sformatf("pc3_ack_c%0d", k), 32'(ack0_b), 32'(k == 7));
        end
        tick();
        chk("pc3_busy_after", 32'(busy_b), 32'd0);
        req0_b = 1'b0;
        tick();

        // 6: reset during DATA aborts without ACK; next request starts with ADDR
        issue(0, 1'b0, 1'b1, 4'd5, 8'h66, 1'b0, 1'b0, 8'h00, 0, "abort");
        tick(); chk_bus_a("abort_addr_phase", PSG_BUS_ADDR, 8'h05);
        tick(); chk_bus_a("abort_data_phase", PSG_BUS_WRITE, 8'h66);
        rst_n = 1'b0;
        #1;
        chk_bus_a("abort_bus_idle", PSG_BUS_IDLE, 8'h00);
        chk("abort_busy", 32'(busy_a), 32'd0);
        chk("abort_rdata1_cleared", 32'(rdata1_a), 32'h00);
        req0_a = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        run_write0(4'd5, 8'h66, 1'b0, "post_reset");

        tick(); tick();
        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
